vx_execute_serializer: RTL and testbench
========================================

// Module: vx_execute_serializer
// PURPOSE
//  Lane serializer between dispatch and a functional unit narrower than the warp.
//  Accepts one full-warp execute packet (NUM_THREADS_IN lanes) per valid/ready handshake.
//  Emits it as NUM_PACKETS = NUM_THREADS_IN/NUM_LANES beats of NUM_LANES lanes each,
//  tagged with pid/sop/eop, on a registered valid/ready execute output.
// PARAMETERS
//  NUM_THREADS_IN  `NUM_THREADS              lanes in the input packet
//  NUM_LANES       4                         lanes per output beat; must divide NUM_THREADS_IN (elaboration $error otherwise)
//  PID_WIDTH       `LOG2UP(NUM_THREADS_IN/NUM_LANES)  beat index width
// PORTS
//  clk        in   1                        clock
//  reset_n    in   1                        asynchronous active-low reset
//  in_valid   in   1                        input packet valid
//  in_hdr     in   $bits(exe_hdr_t)         uuid,wid,PC,op_type,op_args,wb,rd,tid,infl_id
//  in_tmask   in   NUM_THREADS_IN           input thread mask
//  in_rs1     in   NUM_THREADS_IN*`XLEN     operand 1, lane-major
//  in_rs2     in   NUM_THREADS_IN*`XLEN     operand 2
//  in_rs3     in   NUM_THREADS_IN*`XLEN     operand 3
//  in_ready   out  1                        input accepted when in_valid&&in_ready
//  out_valid  out  1                        beat valid (registered)
//  out_hdr    out  $bits(exe_hdr_t)         header copied unchanged to every beat
//  out_tmask  out  NUM_LANES                tmask slice [pid*NUM_LANES +: NUM_LANES]
//  out_rs1/2/3 out NUM_LANES*`XLEN          operand slices, same indexing
//  out_pid    out  PID_WIDTH                beat index (slice number)
//  out_sop    out  1                        first beat of packet
//  out_eop    out  1                        last beat of packet
//  out_ready  in   1                        consumer ready
// BEHAVIOUR
//  - Reset (reset_n low, async): state=IDLE; out_valid=0; out_pid=0; out_sop/eop=0.
//    Data registers are cleared to 0. in_ready=0 while reset_n is low.
//  - FSM IDLE/SEND. in_ready = (state==IDLE) || (out_valid && out_ready && out_eop). This is combinational on out_ready.
//  - Accept: the full input packet is latched. The next cycle out_valid=1 with the first beat (latency 1), and state=SEND.
//  - In SEND, the out_* fields are stable while out_valid && !out_ready. A beat advances only on out_valid&&out_ready.
//  - Advance on a non-eop beat: pid moves to the next emitted slice and sop=0.
//  - eop beat consumed together with an accepted new packet: load the new packet, emit its first beat the next cycle, no bubble.
//  - eop beat consumed with no new packet: out_valid=0 and state=IDLE.
//  - Throughput: one beat per cycle. A packet takes NUM_PACKETS beats (fewer with skip mode).
//  - NUM_LANES==NUM_THREADS_IN: a single beat with pid=0 and sop=eop=1. It is still registered, with latency 1.
//  - pid never wraps mid-packet. The eop beat is always the last slice emitted.
// CONFIGURATION
//  EXE_SERIALIZER_SKIP_EMPTY_EN defined:
//  - Slices whose tmask slice is all-zero are not emitted.
//  - The first beat is the lowest nonzero slice. Each next beat is the next higher nonzero slice.
//  - eop is set when no higher nonzero slice remains.
//  - An all-zero in_tmask emits exactly one beat: pid=0, tmask=0, sop=eop=1. This preserves infl_id commit.
//  Undefined: all NUM_PACKETS beats are emitted in order 0..NUM_PACKETS-1, including empty slices.
// STRUCTURE
//  - VX_gpu_pkg gets typedef exe_hdr_t, packed {uuid,wid,PC,op_type,op_args,wb,rd,tid,infl_id}.
//  - VX_gpu_pkg gets a function exe_num_packets(threads,lanes).
//  - Sub-module vx_lane_slice_finder: per-slice OR of tmask, masked above the current pid, then a priority encoder.
//    It returns next_pid and has_next. It is instantiated only under EXE_SERIALIZER_SKIP_EMPTY_EN.
// TESTING  (NUM_THREADS_IN=8, NUM_LANES=2 unless stated)
//  1. tmask=8'hFF, rs1 lane i=i, out_ready=1 -> 4 beats pid 0,1,2,3.
//     out_rs1 of beat k = {2k+1,2k}; sop only on pid0, eop only on pid3; in_ready=1 only during the pid3 beat.
//  2. Random out_ready at 50% -> scoreboard sees each slice exactly once.
//     Fields are unchanged across stalled cycles.
//  3. Two packets back-to-back (in_valid held) -> pid3/eop of pkt A, then pid0/sop of pkt B on the next cycle, no gap.
//  4. SKIP_EN on: tmask=8'b0011_0000 -> one beat pid2 sop=eop=1.
//     tmask=8'b1000_0001 -> pid0 (sop), then pid3 (eop).
//     tmask=0 -> one beat pid0, tmask=0. With SKIP_EN off: 4 beats each.
//  5. reset_n low during pid1 beat -> out_valid=0 immediately.
//     After release: IDLE, in_ready=1, and the next packet starts at pid0 with sop.
//  6. NUM_LANES=8 -> every packet is one beat pid0 sop=eop=1, one cycle after accept.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg: execute header type and serializer helpers shared by dispatch-side blocks.
// Supplies fallback NUM_THREADS/XLEN/LOG2UP macros when the build does not define them.
`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package VX_gpu_pkg;

    localparam int UUID_BITS    = 16;
    localparam int NW_BITS      = 2;
    localparam int OP_TYPE_BITS = 4;
    localparam int OP_ARGS_BITS = 16;
    localparam int NR_BITS      = 5;
    localparam int NT_BITS      = `LOG2UP(`NUM_THREADS);
    localparam int INFL_BITS    = 4;

    typedef struct packed {
        logic [UUID_BITS-1:0]    uuid;
        logic [NW_BITS-1:0]      wid;
        logic [`XLEN-1:0]        PC;
        logic [OP_TYPE_BITS-1:0] op_type;
        logic [OP_ARGS_BITS-1:0] op_args;
        logic                    wb;
        logic [NR_BITS-1:0]      rd;
        logic [NT_BITS-1:0]      tid;
        logic [INFL_BITS-1:0]    infl_id;
    } exe_hdr_t;

    function automatic int exe_num_packets(input int threads, input int lanes);
        return threads / lanes;
    endfunction

endpackage

// File: rtl/vx_lane_slice_finder.sv
// vx_lane_slice_finder: lowest non-empty tmask slice at or above lo, plus whether any
// non-empty slice lies beyond it.
module vx_lane_slice_finder #(
    parameter int NUM_THREADS_IN = 8,
    parameter int NUM_LANES      = 4,
    parameter int PID_WIDTH      = 1
) (
    input  logic [NUM_THREADS_IN-1:0] tmask,
    input  logic [PID_WIDTH:0]        lo,
    output logic [PID_WIDTH-1:0]      next_pid,
    output logic                      has_next,
    output logic                      has_after
);

    localparam int NP = NUM_THREADS_IN / NUM_LANES;

    logic [NP-1:0] slice_nz, above;

    always_comb begin
        slice_nz  = '0;
        above     = '0;
        next_pid  = '0;
        has_next  = 1'b0;
        has_after = 1'b0;
        for (int i = 0; i < NP; i++) begin
            slice_nz[i] = |tmask[i*NUM_LANES +: NUM_LANES];
            above[i]    = slice_nz[i] && (i >= int'(lo));
        end
        for (int i = NP - 1; i >= 0; i--) begin
            if (above[i]) begin
                next_pid = PID_WIDTH'(i);
                has_next = 1'b1;
            end
        end
        for (int i = 0; i < NP; i++)
            if (above[i] && i > int'(next_pid)) has_after = 1'b1;
    end

endmodule

// File: rtl/vx_execute_serializer.sv
// vx_execute_serializer: splits a full-warp execute packet into NUM_LANES-wide beats tagged pid/sop/eop.
// Define EXE_SERIALIZER_SKIP_EMPTY_EN to drop beats whose tmask slice is all-zero.
`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module vx_execute_serializer import VX_gpu_pkg::*; #(
    parameter int NUM_THREADS_IN = `NUM_THREADS,
    parameter int NUM_LANES      = 4,
    parameter int PID_WIDTH      = `LOG2UP(NUM_THREADS_IN / NUM_LANES)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    input  exe_hdr_t                          in_hdr,
    input  logic [NUM_THREADS_IN-1:0]         in_tmask,
    input  logic [NUM_THREADS_IN*`XLEN-1:0]   in_rs1,
    input  logic [NUM_THREADS_IN*`XLEN-1:0]   in_rs2,
    input  logic [NUM_THREADS_IN*`XLEN-1:0]   in_rs3,
    output logic                              in_ready,
    output logic                              out_valid,
    output exe_hdr_t                          out_hdr,
    output logic [NUM_LANES-1:0]              out_tmask,
    output logic [NUM_LANES*`XLEN-1:0]        out_rs1,
    output logic [NUM_LANES*`XLEN-1:0]        out_rs2,
    output logic [NUM_LANES*`XLEN-1:0]        out_rs3,
    output logic [PID_WIDTH-1:0]              out_pid,
    output logic                              out_sop,
    output logic                              out_eop,
    input  logic                              out_ready
);

    localparam int NUM_PACKETS = exe_num_packets(NUM_THREADS_IN, NUM_LANES);
    localparam int BW          = NUM_LANES * `XLEN;

    if (NUM_THREADS_IN % NUM_LANES != 0) begin : g_bad_lanes
        $error("vx_execute_serializer: NUM_LANES must divide NUM_THREADS_IN");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state, state_n;
    exe_hdr_t                    hdr_q;
    logic [NUM_THREADS_IN-1:0]   tmask_q;
    logic [NUM_THREADS_IN*`XLEN-1:0] rs1_q, rs2_q, rs3_q;
    logic [PID_WIDTH-1:0]        pid_q, first_pid, next_pid;
    logic                        sop_q, eop_q, first_eop, next_eop, load, fire;

    assign out_valid = (state == SEND);
    assign fire      = out_valid && out_ready;
    assign in_ready  = reset_n && (!out_valid || (out_ready && eop_q));
    assign load      = in_valid && in_ready;

`ifdef EXE_SERIALIZER_SKIP_EMPTY_EN
    logic [PID_WIDTH-1:0] f_pid, n_pid;
    logic                 f_has, f_after, n_has, n_after;
    logic [PID_WIDTH:0]   next_lo;

    assign next_lo = (PID_WIDTH+1)'(pid_q) + (PID_WIDTH+1)'(1);

    vx_lane_slice_finder #(
        .NUM_THREADS_IN (NUM_THREADS_IN),
        .NUM_LANES      (NUM_LANES),
        .PID_WIDTH      (PID_WIDTH)
    ) u_first (
        .tmask     (in_tmask),
        .lo        ('0),
        .next_pid  (f_pid),
        .has_next  (f_has),
        .has_after (f_after)
    );

    vx_lane_slice_finder #(
        .NUM_THREADS_IN (NUM_THREADS_IN),
        .NUM_LANES      (NUM_LANES),
        .PID_WIDTH      (PID_WIDTH)
    ) u_next (
        .tmask     (tmask_q),
        .lo        (next_lo),
        .next_pid  (n_pid),
        .has_next  (n_has),
        .has_after (n_after)
    );

    // An all-zero mask still emits one beat at pid 0 so infl_id gets committed.
    assign first_pid = f_has ? f_pid : '0;
    assign first_eop = !f_after;
    assign next_pid  = n_has ? n_pid : pid_q;
    assign next_eop  = !n_after;
`else
    assign first_pid = '0;
    assign first_eop = (NUM_PACKETS == 1);
    assign next_pid  = pid_q + 1'b1;
    assign next_eop  = (int'(pid_q) + 2 == NUM_PACKETS);
`endif

    always_comb begin
        state_n = state;
        if (load)
            state_n = SEND;
        else if (fire && eop_q)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q   <= '0;
            tmask_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else if (load) begin
            hdr_q   <= in_hdr;
            tmask_q <= in_tmask;
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            rs3_q   <= in_rs3;
            pid_q   <= first_pid;
            sop_q   <= 1'b1;
            eop_q   <= first_eop;
        end else if (fire) begin
            pid_q   <= eop_q ? '0 : next_pid;
            sop_q   <= 1'b0;
            eop_q   <= eop_q ? 1'b0 : next_eop;
        end
    end

    assign out_hdr   = hdr_q;
    assign out_pid   = pid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_tmask = tmask_q[int'(pid_q)*NUM_LANES +: NUM_LANES];
    assign out_rs1   = rs1_q[int'(pid_q)*BW +: BW];
    assign out_rs2   = rs2_q[int'(pid_q)*BW +: BW];
    assign out_rs3   = rs3_q[int'(pid_q)*BW +: BW];

endmodule

// File: tb/tb_vx_execute_serializer.sv
// tb_vx_execute_serializer: randomized scoreboard bench for the lane serializer (8 threads, 2 lanes),
// plus a single-beat instance with NUM_LANES equal to the warp width.
`timescale 1ns/1ps
module tb_vx_execute_serializer;
    import VX_gpu_pkg::*;

    localparam int T  = 8;
    localparam int L  = 2;
    localparam int NP = T / L;
    localparam int PW = 2;
    localparam int X  = 32;
    localparam int HW = $bits(exe_hdr_t);

    typedef struct packed {
        logic [PW-1:0]  pid;
        logic           sop;
        logic           eop;
        logic [L-1:0]   tm;
        logic [L*X-1:0] r1;
        logic [L*X-1:0] r2;
        logic [L*X-1:0] r3;
        logic [HW-1:0]  hdr;
    } beat_t;

    logic           clk, reset_n, in_valid, in_ready, out_valid, out_sop, out_eop, out_ready;
    logic [HW-1:0]  in_hdr, out_hdr;
    logic [T-1:0]   in_tmask;
    logic [T*X-1:0] in_rs1, in_rs2, in_rs3;
    logic [L-1:0]   out_tmask;
    logic [L*X-1:0] out_rs1, out_rs2, out_rs3;
    logic [PW-1:0]  out_pid;

    logic           in_valid8, in_ready8, out_valid8, out_sop8, out_eop8;
    logic [HW-1:0]  out_hdr8;
    logic [T-1:0]   out_tmask8;
    logic [T*X-1:0] out_rs1_8, out_rs2_8, out_rs3_8;
    logic [0:0]     out_pid8;

    vx_execute_serializer #(.NUM_THREADS_IN(T), .NUM_LANES(L)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_hdr(in_hdr), .in_tmask(in_tmask),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_ready(in_ready),
        .out_valid(out_valid), .out_hdr(out_hdr), .out_tmask(out_tmask), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rs3(out_rs3), .out_pid(out_pid), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready)
    );

    vx_execute_serializer #(.NUM_THREADS_IN(T), .NUM_LANES(T)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_hdr(in_hdr), .in_tmask(in_tmask),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_hdr(out_hdr8), .out_tmask(out_tmask8), .out_rs1(out_rs1_8),
        .out_rs2(out_rs2_8), .out_rs3(out_rs3_8), .out_pid(out_pid8), .out_sop(out_sop8),
        .out_eop(out_eop8), .out_ready(1'b1)
    );

    int       n_cmp = 0, n_err = 0;
    bit       rnd = 0;
    beat_t    q[$];
    logic [X-1:0] r1 [T], r2 [T], r3 [T];
    logic [T-1:0] cur_tm;
    logic [HW-1:0] cur_hdr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: list the slices the spec says get emitted, then build each beat from lanes.
    task automatic push_pkt();
        int    ks[$];
        beat_t b;
        for (int k = 0; k < NP; k++) begin
`ifdef EXE_SERIALIZER_SKIP_EMPTY_EN
            bit nz = 0;
            for (int j = 0; j < L; j++) if (cur_tm[k*L + j]) nz = 1;
            if (nz) ks.push_back(k);
`else
            ks.push_back(k);
`endif
        end
        if (ks.size() == 0) ks.push_back(0);
        foreach (ks[i]) begin
            b.pid = PW'(ks[i]);
            b.sop = (i == 0);
            b.eop = (i == ks.size() - 1);
            b.hdr = cur_hdr;
            for (int j = 0; j < L; j++) begin
                b.tm[j]          = cur_tm[ks[i]*L + j];
                b.r1[j*X +: X]   = r1[ks[i]*L + j];
                b.r2[j*X +: X]   = r2[ks[i]*L + j];
                b.r3[j*X +: X]   = r3[ks[i]*L + j];
            end
            q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Input side: record accepted packets and check first-beat latency.
    bit acc_prev = 0;
    always @(negedge clk) begin
        if (!reset_n) acc_prev = 0;
        else begin
            if (acc_prev) check("first_beat_latency", 512'(out_valid), 512'(1));
            acc_prev = in_valid && in_ready;
            if (acc_prev) push_pkt();
        end
    end

    // Output side: pop and compare every consumed beat; hold check while stalled.
    bit    stalled = 0;
    beat_t held, act;
    always @(negedge clk) begin
        if (!reset_n) stalled = 0;
        else begin
            act = {out_pid, out_sop, out_eop, out_tmask, out_rs1, out_rs2, out_rs3, out_hdr};
            check("in_ready_rule", 512'(in_ready), 512'(!out_valid || (out_ready && out_eop)));
            if (stalled) check("stall_hold", 512'(act), 512'(held));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_beat", 512'(act), 512'(0));
                else check("beat", 512'(act), 512'(q.pop_front()));
            end
            stalled = out_valid && !out_ready;
            held = act;
        end
    end

    task automatic load_bus(input logic [T-1:0] tm, input bit lane_idx);
        logic [HW-1:0] h;
        for (int b = 0; b < HW; b++) h[b] = 1'($urandom_range(0, 1));
        cur_tm = tm; cur_hdr = h; in_tmask = tm; in_hdr = h;
        for (int i = 0; i < T; i++) begin
            r1[i] = lane_idx ? X'(i) : X'($urandom);
            r2[i] = X'($urandom);
            r3[i] = X'($urandom);
            in_rs1[i*X +: X] = r1[i];
            in_rs2[i*X +: X] = r2[i];
            in_rs3[i*X +: X] = r3[i];
        end
    endtask

    task automatic send_pkt(input logic [T-1:0] tm, input bit lane_idx);
        load_bus(tm, lane_idx);
        in_valid = 1'b1;
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (in_ready) break;
            if (c > 300) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", c);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
            if (c > 500) begin
                n_cmp++; n_err++;
                $display("FAIL drain_timeout: %0d beats still expected", q.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
        in_tmask = '0; in_hdr = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_pid_sop_eop", 512'({out_pid, out_sop, out_eop}), 512'(0));
        check("rst_tmask", 512'(out_tmask), 512'(0));
        check("rst_out_valid8", 512'(out_valid8), 512'(0));
        @(negedge clk); #2 reset_n = 1'b1; #1;
        check("idle_in_ready", 512'(in_ready), 512'(1));
        @(posedge clk); #1;

        // full mask, rs1 lane i = i
        send_pkt(8'hFF, 1); in_valid = 1'b0; wait_drain();

        // back-to-back packets with in_valid held
        send_pkt(8'hFF, 0); send_pkt(8'h5A, 0); in_valid = 1'b0; wait_drain();

        // sparse masks
        send_pkt(8'b0011_0000, 0); in_valid = 1'b0; wait_drain();
        send_pkt(8'b1000_0001, 0); in_valid = 1'b0; wait_drain();
        send_pkt(8'h00, 0);        in_valid = 1'b0; wait_drain();

        // random backpressure and random masks
        rnd = 1;
        for (int n = 0; n < 30; n++) begin
            int m = $urandom_range(0, 3);
            logic [T-1:0] tm = (m == 0) ? 8'h00 : (m == 1) ? 8'(1 << $urandom_range(0, T-1)) : 8'($urandom);
            send_pkt(tm, 0);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0; wait_drain();
        rnd = 0;

        // async reset during the pid1 beat
        @(posedge clk); #1;
        send_pkt(8'hFF, 0); in_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0; #1;
        check("midrst_out_valid", 512'(out_valid), 512'(0));
        check("midrst_in_ready", 512'(in_ready), 512'(0));
        check("midrst_pid", 512'({out_pid, out_sop, out_eop}), 512'(0));
        q.delete();
        @(negedge clk); #2 reset_n = 1'b1; #1;
        check("postrst_in_ready", 512'(in_ready), 512'(1));
        check("postrst_out_valid", 512'(out_valid), 512'(0));
        @(posedge clk); #1;
        send_pkt(8'hC3, 0); in_valid = 1'b0; wait_drain();

        // single-beat configuration
        load_bus(8'($urandom), 0);
        in_valid8 = 1'b1;
        @(negedge clk);
        check("w8_in_ready", 512'(in_ready8), 512'(1));
        @(posedge clk); #1 in_valid8 = 1'b0;
        @(negedge clk);
        check("w8_valid", 512'(out_valid8), 512'(1));
        check("w8_pid_sop_eop", 512'({out_pid8, out_sop8, out_eop8}), 512'(3'b011));
        check("w8_tmask", 512'(out_tmask8), 512'(cur_tm));
        check("w8_rs", 512'({out_rs1_8, out_rs2_8}), 512'({in_rs1, in_rs2}));
        check("w8_rs3_hdr", 512'({out_rs3_8, out_hdr8}), 512'({in_rs3, cur_hdr}));
        @(negedge clk);
        check("w8_done", 512'(out_valid8), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
